instr_reader: RTL

- Read-side sequencer and checker for the instruction register.
- On a start command it walks a range of register slots by driving read_pointer, and captures each instruction_word.
- For each word it recomputes the expected result from opcode and operands, and compares that with the stored result field.
- Each checked word is presented downstream on a valid/ready stream, together with a mismatch flag; a running error count is kept per run.

---
 rtl/instr_register_pkg.sv | 38 +++
 rtl/instr_expected_calc.sv | 58 +++++
 rtl/instr_reader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the blocks that read it.
package instr_register_pkg;

    localparam int REG_DEPTH   = 32;
    localparam int ADDR_W      = 5;
    localparam int ERR_CNT_MAX = 63;

    typedef enum logic [2:0] {
        OP_ZERO  = 3'd0,
        OP_PASSA = 3'd1,
        OP_PASSB = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_MULT  = 3'd5,
        OP_DIV   = 3'd6,
        OP_MOD   = 3'd7
    } opcode_t;

    typedef logic signed [31:0]     operand_t;
    typedef logic signed [63:0]     result_t;
    typedef logic [ADDR_W-1:0]      address_t;

    typedef struct packed {
        opcode_t  opcode;
        operand_t operand_a;
        operand_t operand_b;
        result_t  result;
    } instruction_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CALC    = 3'd2,
        PRESENT = 3'd3,
        FINISH  = 3'd4
    } reader_state_t;

endpackage

// File: rtl/instr_expected_calc.sv
// Combinational recomputation of an instruction's result from its opcode and
// operands, with a flag for division or modulo by zero.
module instr_expected_calc
    import instr_register_pkg::*;
(
    input  opcode_t  opcode,
    input  operand_t operand_a,
    input  operand_t operand_b,
    output result_t  expected,
    output logic     div0
);

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    operand_t    safe_b;
    operand_t    quotient;
    operand_t    remainder;
    logic        b_is_zero;
    logic        div_overflow;

    // A zero divisor or the single overflowing case (most negative / -1) is
    // replaced by 1, which yields the wrapped 32-bit quotient and zero remainder.
    always_comb begin
        ext_a        = {{32{operand_a[31]}}, operand_a};
        ext_b        = {{32{operand_b[31]}}, operand_b};
        b_is_zero    = (operand_b == 32'sd0);
        div_overflow = (operand_a == 32'sh8000_0000) && (operand_b == -32'sd1);
        safe_b       = (b_is_zero || div_overflow) ? 32'sd1 : operand_b;
        quotient     = operand_a / safe_b;
        remainder    = operand_a % safe_b;
        expected     = '0;
        div0         = 1'b0;
        case (opcode)
            OP_ZERO:  expected = '0;
            OP_PASSA: expected = result_t'(ext_a);
            OP_PASSB: expected = result_t'(ext_b);
            OP_ADD:   expected = result_t'(ext_a + ext_b);
            OP_SUB:   expected = result_t'(ext_a - ext_b);
            OP_MULT:  expected = $signed(ext_a) * $signed(ext_b);
            OP_DIV: begin
                if (b_is_zero) begin
                    div0 = 1'b1;
                end else begin
                    expected = {{32{quotient[31]}}, quotient};
                end
            end
            OP_MOD: begin
                if (b_is_zero) begin
                    div0 = 1'b1;
                end else begin
                    expected = {{32{remainder[31]}}, remainder};
                end
            end
            default: expected = '0;
        endcase
    end

endmodule

// File: rtl/instr_reader.sv
// Walks a range of instruction register slots, recomputes each stored result
// and streams every checked word downstream with a mismatch flag.
module instr_reader
    import instr_register_pkg::*;
#(
    parameter int DEPTH    = REG_DEPTH,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  address_t     first_addr,
    input  logic [5:0]   count,
    output logic         busy,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         out_valid,
    input  logic         out_ready,
    output instruction_t out_instr,
    output address_t     out_addr,
    output result_t      out_expected,
    output logic         out_mismatch,
    output logic         out_div0,
    output logic         done,
    output logic [5:0]   error_count
);

    reader_state_t state;
    reader_state_t state_next;
    address_t      addr;
    address_t      addr_next;
    logic [5:0]    remaining;
    instruction_t  captured;
    result_t       calc_expected;
    logic          calc_div0;

    instr_expected_calc u_calc (
        .opcode    (captured.opcode),
        .operand_a (captured.operand_a),
        .operand_b (captured.operand_b),
        .expected  (calc_expected),
        .div0      (calc_div0)
    );

    assign addr_next = (addr == address_t'(DEPTH - 1)) ? '0 : addr + address_t'(1);
    assign out_addr  = addr;
    assign out_instr = captured;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the state-derived handshake/status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (count != 6'd0) ? FETCH : FINISH;
                end
            end
            FETCH: begin
                busy       = 1'b1;
                state_next = CALC;
            end
            CALC: begin
                busy       = 1'b1;
                state_next = PRESENT;
            end
            PRESENT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = (remaining == 6'd1) ? FINISH : FETCH;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Run bookkeeping, word capture, result check and error counting.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr         <= '0;
            remaining    <= '0;
            read_pointer <= '0;
            captured     <= '0;
            out_expected <= '0;
            out_mismatch <= 1'b0;
            out_div0     <= 1'b0;
            error_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        error_count <= '0;
                        if (count != 6'd0) begin
                            addr         <= first_addr;
                            remaining    <= count;
                            read_pointer <= first_addr;
                        end
                    end
                end
                FETCH: begin
                    captured <= instruction_word;
                end
                CALC: begin
                    out_expected <= CHECK_EN ? calc_expected : '0;
                    out_div0     <= calc_div0;
                    out_mismatch <= CHECK_EN && !calc_div0 &&
                                    (calc_expected != captured.result);
                end
                PRESENT: begin
                    if (out_ready) begin
                        if (out_mismatch && (error_count != 6'(ERR_CNT_MAX))) begin
                            error_count <= error_count + 6'd1;
                        end
                        remaining <= remaining - 6'd1;
                        addr      <= addr_next;
                        if (remaining != 6'd1) begin
                            read_pointer <= addr_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
